rah_app_frame_echo: RTL
=======================

// Module: rah_app_frame_echo
// PURPOSE
//  RAH application endpoint between one rah_decoder app queue and the matching rah_encoder write port.
//  Reads 48-bit RAH words, parses {header, N payload} frames and echoes each frame back out.
//  Each echoed frame is the header, then the payload, then an appended checksum trailer.
//  Oversize frames are consumed and dropped. An internal FIFO decouples decoder read latency from encoder backpressure.
// PARAMETERS
//  DATA_WIDTH  48   RAH packet word width; fixed at 48, other values unsupported
//  MAX_WORDS   256  largest legal payload word count N
//  FIFO_DEPTH  16   internal output FIFO depth in words; power of 2, >=4
// PORTS
//  clk      in   1   application clock; all logic on posedge
//  rstn     in   1   asynchronous active-low reset
//  empty    in   1   decoder app queue empty
//  rden     out  1   decoder app queue read request; data returns next cycle
//  datain   in   48  decoder app queue read data; valid the cycle after rden
//  wr_full  in   1   encoder app FIFO (prog) full; no write while high
//  wren     out  1   encoder app FIFO write strobe
//  dataout  out  48  encoder app FIFO write data; valid with wren
//  busy     out  1   high whenever state!=IDLE or the FIFO is non-empty
//  err_ovf  out  1   one-cycle pulse when an oversize header is captured
// BEHAVIOUR
//  Reset (async assert, sync release): rden=0, wren=0, dataout=0, busy=0, err_ovf=0.
//   Reset also forces state=IDLE, empties the FIFO, zeroes the sum, and discards any in-flight read.
//  Header format: [47:40] opcode, [39:16] don't-care, [15:0] N.
//  Trailer format: {16'hC5C5, sum[31:0]}. sum = wrapping mod-2^32 sum of payload datain[31:0]; N=0 gives sum 0.
//  Read rule: rden = !empty & state in {IDLE,HDR,PAYLOAD,DROP} & (fifo_count + inflight) < FIFO_DEPTH-1.
//   Exactly one read may be in flight; rden is registered, and the capture strobe is rden delayed 1 cycle.
//  FSM (advances on capture strobes):
//   IDLE   : first read issued -> HDR
//   HDR    : header captured; N>MAX_WORDS -> pulse err_ovf, no push, cnt=N, -> DROP
//            N==0 -> push header -> TRAILER
//            else -> push header, cnt=N, sum=0 -> PAYLOAD
//   PAYLOAD: each capture pushes the word, adds [31:0] to sum, decrements cnt; cnt hits 0 -> TRAILER.
//            No read is issued that would overrun the frame: reads issued <= cnt.
//   TRAILER: no reads; push trailer once the FIFO has space -> IDLE
//   DROP   : capture and discard cnt words without pushing; cnt hits 0 -> IDLE
//  Output side: wren = fifo_nonempty & !wr_full. dataout = FIFO head, registered with wren, zero when idle.
//   Pop and push in the same cycle are legal; the count is unchanged.
//  Full FIFO: reads stall and no word is ever lost. Empty FIFO: wren=0.
//  wr_full held high indefinitely: the FIFO fills, reads stall, and the decoder queue absorbs the backlog.
//  Latency: header capture to first wren is 2 cycles when the FIFO is empty and wr_full=0.
//  Back-to-back frames: a new header read may issue in the cycle after the trailer push.
// CONFIGURATION
//  RAH_ECHO_STATS_EN defined: adds outputs pkt_cnt[15:0] and drop_cnt[15:0].
//   Both reset to 0 and wrap at 16'hFFFF.
//   pkt_cnt increments on each trailer push; drop_cnt increments on each err_ovf.
//  Undefined: those ports and counters are absent; everything else is identical.
// STRUCTURE
//  rah_echo_defs.vh (shared include): state encodings, trailer tag 16'hC5C5, header field bit positions, N width.
//  Sub-module rah_echo_fifo: sync FIFO, FIFO_DEPTH x 48, with push/pop/count/full/empty.
//   Async active-low reset; push when full is ignored and is a bench assertion error.
// TESTING
//  T1 Frame: header N=3 with payload 1,2,3 and wr_full=0
//     -> out hdr,1,2,3,{C5C5,00000006}.
//  T2 Zero length: header N=0 -> out hdr then {C5C5,00000000}; FSM returns to IDLE.
//  T3 Oversize: header N=300 followed by 300 words
//     -> err_ovf pulses once, no wren for that frame, next frame echoes correctly.
//  T4 Backpressure: N=40 with wr_full=1 for 100 cycles
//     -> fifo_count peaks at FIFO_DEPTH-1, rden stalls, all 42 words come out in order after release.
//  T5 Wrap: two payload words of 0xFFFFFFFF -> trailer sum 0xFFFFFFFE.
//  T6 Mid-frame reset: rstn low after 2 of 5 payload words
//     -> all outputs 0, FIFO empty; a subsequent full frame echoes cleanly.
//     With RAH_ECHO_STATS_EN defined, pkt_cnt==1 after that frame.

Source files
------------

// File: rtl/rah_app_frame_echo_pkg.sv
// Shared definitions for the RAH frame echo endpoint: FSM encodings, header fields, trailer format.
package rah_app_frame_echo_pkg;

  localparam int          RAH_DW      = 48;
  localparam int          HDR_N_W     = 16;
  localparam int          HDR_N_LSB   = 0;
  localparam logic [15:0] TRAILER_TAG = 16'hC5C5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_TRAILER = 3'd3;
  localparam logic [2:0] ST_DROP    = 3'd4;

  function automatic logic [RAH_DW-1:0] make_trailer(input logic [31:0] sum);
    return {TRAILER_TAG, sum};
  endfunction

endpackage

// File: rtl/rah_app_frame_echo_if.sv
// Decoder read port plus encoder write port of the echo endpoint.
// master = echo endpoint side, slave = decoder/encoder side.
interface rah_app_frame_echo_if #(
  parameter int DATA_WIDTH = 48
);
  logic                  empty;
  logic                  rden;
  logic [DATA_WIDTH-1:0] datain;
  logic                  wr_full;
  logic                  wren;
  logic [DATA_WIDTH-1:0] dataout;

  modport master (input empty, output rden, input datain,
                  input wr_full, output wren, output dataout);
  modport slave  (output empty, input rden, output datain,
                  output wr_full, input wren, input dataout);
endinterface

// File: rtl/rah_echo_fifo.sv
// Purpose: synchronous DEPTH x DW FIFO with occupancy count; head word visible combinationally.
// Latency: push visible at dout one cycle later when previously empty.
// Backpressure: push while full is ignored; pop while empty is ignored.
module rah_echo_fifo #(
  parameter  int DW    = 48,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rah_app_frame_echo.sv
// Purpose: echo RAH {header, N payload} frames with a {C5C5, sum32} trailer; oversize frames dropped (RAH_ECHO_STATS_EN adds counters).
// Latency: header capture to first wren is 2 cycles with an empty FIFO and wr_full low.
// Backpressure: wr_full stalls output pops; reads stall while FIFO count plus the in-flight read reaches FIFO_DEPTH-1.
module rah_app_frame_echo
  import rah_app_frame_echo_pkg::*;
#(
  parameter int DATA_WIDTH = 48,
  parameter int MAX_WORDS  = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  rah_app_frame_echo_if.master app,
  output logic                 busy,
  output logic                 err_ovf
`ifdef RAH_ECHO_STATS_EN
  ,
  output logic [15:0]          pkt_cnt,
  output logic [15:0]          drop_cnt
`endif
);
  localparam int                 CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]      RD_LIMIT = CW'(FIFO_DEPTH - 1);
  localparam logic [HDR_N_W-1:0] MAX_N    = HDR_N_W'(MAX_WORDS);
  localparam logic [HDR_N_W-1:0] ONE_N    = HDR_N_W'(1);

  logic [2:0]            state, state_nxt;
  logic                  rden_q, cap_q, rden_nxt;
  logic [HDR_N_W-1:0]    cnt, hdr_n;
  logic [31:0]           sum;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_din, fifo_dout;
  logic [CW-1:0]         fifo_count, inflight;
  logic                  room;
  logic                  wren_q;
  logic [DATA_WIDTH-1:0] dout_q;

  assign hdr_n    = app.datain[HDR_N_LSB +: HDR_N_W];
  assign inflight = {{(CW-1){1'b0}}, rden_q | cap_q};
  assign room     = (fifo_count + inflight) < RD_LIMIT;

  // Only one read outstanding; at a capture, the word being captured still counts against cnt.
  always_comb begin
    rden_nxt = 1'b0;
    if (!app.empty && !rden_q && room) begin
      case (state)
        ST_IDLE:             rden_nxt = 1'b1;
        ST_HDR:              rden_nxt = cap_q && (hdr_n != '0);
        ST_PAYLOAD, ST_DROP: rden_nxt = cnt > {{(HDR_N_W-1){1'b0}}, cap_q};
        default:             rden_nxt = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_push = 1'b0;
    fifo_din  = app.datain;
    case (state)
      ST_IDLE: if (rden_nxt) state_nxt = ST_HDR;
      ST_HDR: begin
        if (cap_q) begin
          if (hdr_n > MAX_N) begin
            state_nxt = ST_DROP;
          end else begin
            fifo_push = 1'b1;
            state_nxt = (hdr_n == '0) ? ST_TRAILER : ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (cap_q) begin
          fifo_push = 1'b1;
          if (cnt == ONE_N) state_nxt = ST_TRAILER;
        end
      end
      ST_TRAILER: begin
        if (!fifo_full) begin
          fifo_push = 1'b1;
          fifo_din  = make_trailer(sum);
          state_nxt = ST_IDLE;
        end
      end
      ST_DROP: if (cap_q && cnt == ONE_N) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      rden_q  <= 1'b0;
      cap_q   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      err_ovf <= 1'b0;
    end else begin
      state   <= state_nxt;
      rden_q  <= rden_nxt;
      cap_q   <= rden_q;
      err_ovf <= 1'b0;
      if (cap_q) begin
        case (state)
          ST_HDR: begin
            cnt     <= hdr_n;
            sum     <= '0;
            err_ovf <= (hdr_n > MAX_N);
          end
          ST_PAYLOAD: begin
            cnt <= cnt - ONE_N;
            sum <= sum + app.datain[31:0];
          end
          ST_DROP: cnt <= cnt - ONE_N;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  rah_echo_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // dataout is registered alongside wren and held at zero between writes.
  assign fifo_pop = !fifo_empty && !app.wr_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wren_q <= 1'b0;
      dout_q <= '0;
    end else begin
      wren_q <= fifo_pop;
      dout_q <= fifo_pop ? fifo_dout : '0;
    end
  end

  assign app.rden    = rden_q;
  assign app.wren    = wren_q;
  assign app.dataout = dout_q;
  assign busy        = (state != ST_IDLE) || !fifo_empty;

`ifdef RAH_ECHO_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == ST_TRAILER && !fifo_full) pkt_cnt <= pkt_cnt + 16'd1;
      if (err_ovf) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
